// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer for a synchronous word memory.
// Sub-word stores read the word, merge the new lane(s) into it, and write it back.
module mem_access_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        done,
   output logic        misalign,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE, ERR} state_t;
   state_t state, nxt;
   logic [1:0]  lane_q;
   logic [1:0]  size_q;
   logic        write_q;
   logic [31:0] wdata_q;
   logic [31:0] merged;
   logic        acc;
   logic        mis;
   assign acc = req_valid && state == IDLE;
   assign mis = req_size == 2'b11 || (req_size == 2'b01 && addr[0]) || (req_size == 2'b00 && addr[1:0] != 2'b00);
   always_comb begin
      nxt       = state;
      req_ready = 1'b0;
      done      = 1'b0;
      misalign  = 1'b0;
      mem_wr    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) nxt = mis ? ERR : (req_write && req_size == 2'b00) ? WRITE : READ;
         end
         READ:  nxt = WAIT;
         WAIT:  nxt = write_q ? WRITE : DONE;
         WRITE: begin
            mem_wr = 1'b1;
            nxt    = DONE;
         end
         DONE: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         ERR: begin
            done     = 1'b1;
            misalign = 1'b1;
            nxt      = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end
   // rdata holds the word captured in WAIT, so it doubles as the merge base
   always_comb begin
      merged = rdata;
      if (size_q == 2'b10) merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      else if (size_q == 2'b01) merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      mem_wdata = size_q == 2'b00 ? wdata_q : merged;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         rdata    <= '0;
         mem_addr <= '0;
         lane_q   <= '0;
         size_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
      end else begin
         state <= nxt;
         if (acc) begin
            lane_q  <= addr[1:0];
            size_q  <= req_size;
            write_q <= req_write;
            wdata_q <= wdata;
            if (!mis) mem_addr <= {addr[31:2], 2'b00};
         end
         if (state == WAIT) rdata <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized scoreboard bench with a word-level reference memory.
module tb_mem_access_ctrl;
   logic        clk = 0, reset = 0, req_valid = 0, req_write = 0;
   logic [1:0]  req_size = 0;
   logic [31:0] addr = 0, wdata = 0;
   logic        req_ready, done, misalign, mem_wr;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 0;
   logic        booted = 0;
   logic [31:0] mem [256];
   logic [31:0] ref_mem [256];
   logic [31:0] ref_rdata = 0;
   int unsigned cyc = 0;
   int checks = 0, errors = 0;

   typedef struct {
      logic [31:0] rd, maddr, word;
      logic        mis;
      int          lat, nwr, idx;
      int unsigned acc;
   } exp_t;
   exp_t q[$];

   mem_access_ctrl dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .addr(addr), .wdata(wdata),
      .rdata(rdata), .done(done), .misalign(misalign), .mem_addr(mem_addr),
      .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] seed_word(input int i);
      if (i == 4) return 32'hCAFEBABE;
      if (i == 8) return 32'h11223344;
      return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   always @(posedge clk) begin
      if (!booted) begin
         for (int i = 0; i < 256; i++) mem[i] <= seed_word(i);
      end else begin
         if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
         mem_rdata <= mem[mem_addr[9:2]];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic accept_req(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      exp_t e;
      int n;
      int sh;
      logic [31:0] old, mask;
      req_valid = 1; req_write = w; req_size = sz; addr = a; wdata = wd;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("accept_timeout", req_ready, 1);
         return;
      end
      e.idx   = int'(a[9:2]);
      e.maddr = {a[31:2], 2'b00};
      e.acc   = cyc;
      old     = ref_mem[e.idx];
      e.mis   = sz == 3 || (sz == 1 && a[0]) || (sz == 0 && a[1:0] != 0);
      if (e.mis) begin
         e.lat = 1; e.nwr = 0; e.word = old;
      end else if (!w) begin
         e.lat = 3; e.nwr = 0; e.word = old; ref_rdata = old;
      end else if (sz == 0) begin
         e.lat = 2; e.nwr = 1; e.word = wd;
      end else begin
         sh     = sz == 2 ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
         mask   = (sz == 2 ? 32'hFF : 32'hFFFF) << sh;
         e.word = (old & ~mask) | ((wd << sh) & mask);
         e.lat  = 4; e.nwr = 1; ref_rdata = old;
      end
      e.rd = ref_rdata;
      ref_mem[e.idx] = e.word;
      q.push_back(e);
   endtask

   task automatic finish_req(input bit hold);
      int n;
      @(negedge clk);
      req_valid = hold;
      req_write = 1'($urandom); req_size = 2'($urandom); addr = $urandom; wdata = $urandom;
      n = 0;
      while (!done && n < 10) begin
         chk("busy_ready", req_ready, 0);
         @(negedge clk);
         n++;
      end
      chk("done_seen", done, 1);
      chk("done_ready", req_ready, 0);
   endtask

   task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd, input bit hold);
      accept_req(w, sz, a, wd);
      finish_req(hold);
   endtask

   initial begin : monitor
      int unsigned wr_cnt;
      exp_t e;
      wr_cnt = 0;
      forever begin
         @(negedge clk);
         if (!reset) wr_cnt = 0;
         else begin
            if (mem_wr) begin
               wr_cnt++;
               chk("wr_outstanding", q.size(), 1);
               if (q.size() > 0) begin
                  chk("mem_addr", mem_addr, q[0].maddr);
                  chk("mem_wdata", mem_wdata, q[0].word);
               end
            end
            if (done) begin
               chk("done_outstanding", q.size(), 1);
               if (q.size() > 0) begin
                  e = q.pop_front();
                  chk("misalign", misalign, e.mis);
                  chk("rdata", rdata, e.rd);
                  chk("latency", cyc - e.acc, e.lat);
                  chk("wr_count", wr_cnt, e.nwr);
                  chk("mem_word", mem[e.idx], e.word);
               end
               wr_cnt = 0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      logic [31:0] saved, a;
      logic [1:0]  sz;
      int n, diffs;
      for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
      @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_misalign", misalign, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      @(negedge clk);
      booted = 1;
      @(negedge clk);
      reset = 1;
      issue(0, 2'b00, 32'h10, 32'h0, 0);
      issue(1, 2'b10, 32'h22, 32'hAB, 0);
      issue(1, 2'b01, 32'h22, 32'hBEEF, 0);
      issue(1, 2'b01, 32'h23, 32'hBEEF, 0);
      issue(1, 2'b00, 32'h30, 32'h55AA55AA, 1);
      issue(0, 2'b00, 32'h30, 32'h0, 1);
      issue(1, 2'b11, 32'h0, 32'h0, 0);
      saved = ref_mem[17];
      accept_req(1, 2'b10, 32'h44, 32'h5A);
      @(negedge clk);
      req_valid = 0;
      n = 0;
      while (!mem_wr && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("wr_reached", mem_wr, 1);
      #2 reset = 0;
      #1;
      chk("arst_mem_wr", mem_wr, 0);
      chk("arst_rdata", rdata, 0);
      chk("arst_ready", req_ready, 1);
      chk("arst_done", done, 0);
      chk("arst_mem_addr", mem_addr, 0);
      chk("arst_mem_wdata", mem_wdata, 0);
      q.delete();
      ref_rdata = 0;
      ref_mem[17] = saved;
      @(negedge clk);
      @(negedge clk);
      reset = 1;
      repeat (5) begin
         @(negedge clk);
         chk("post_rst_done", done, 0);
      end
      chk("arst_mem_kept", mem[17], saved);
      for (int i = 0; i < 200; i++) begin
         sz = 2'($urandom_range(0, 3));
         a  = $urandom;
         if ($urandom_range(0, 2) != 0) a[1:0] = sz == 2'b10 ? a[1:0] : sz == 2'b01 ? {a[1], 1'b0} : 2'b00;
         issue(1'($urandom), sz, a, $urandom, 1'($urandom));
      end
      @(negedge clk);
      req_valid = 0;
      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
      chk("mem_image_diffs", diffs, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
